// File: rtl/seg_scan_ctrl_if.sv
// Value-load handshake between the display register path and seg_scan_ctrl.
//   in_valid : source has a new packed value
//   in_ready : controller can accept a value
//   in_value : packed nibbles, digit 0 in bits [3:0]
// master = value source, slave = scan controller.
interface seg_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [4*NUM_DIGITS-1:0] in_value;

    modport master (output in_valid, output in_value, input in_ready);
    modport slave  (input in_valid, input in_value, output in_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller sharing one hex-to-7-segment decoder
// across NUM_DIGITS common-anode digits. Each digit gets GAP blank cycles
// followed by DWELL lit cycles; a frame is NUM_DIGITS*(GAP+DWELL) cycles.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   enable       : scan enable, 0 forces all digits dark
//   in_if        : value-load handshake (slave side)
//   hex_num      : nibble to the shared decoder
//   digit_en_n   : active-low digit enables, at most one low
//   frame_done   : one-cycle pulse on the last dwell cycle of a frame
// Optional: define SEG_SCAN_LZB_EN for leading-zero blanking.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DWELL      = 50000,
    parameter int unsigned GAP        = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    seg_scan_ctrl_if.slave        in_if,
    output logic [3:0]            hex_num,
    output logic [NUM_DIGITS-1:0] digit_en_n,
    output logic                  frame_done
);
    localparam int unsigned VW      = 4 * NUM_DIGITS;
    localparam int unsigned IW      = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_SCAN} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [VW-1:0]         disp_q, disp_d;
    logic [VW-1:0]         shadow_q, shadow_d;
    logic                  disp_valid_q, disp_valid_d;
    logic                  pending_q, pending_d;
    logic [3:0]            hex_num_q, hex_num_d;
    logic [NUM_DIGITS-1:0] digit_en_n_q, digit_en_n_d;
    logic                  frame_done_q, frame_done_d;
    logic                  in_ready_q, in_ready_d;
    logic                  xfer_c, boundary_c, lit_c;
`ifdef SEG_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] nz_c;
    logic                  run_c;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            disp_q       <= '0;
            shadow_q     <= '0;
            disp_valid_q <= 1'b0;
            pending_q    <= 1'b0;
            hex_num_q    <= 4'd0;
            digit_en_n_q <= '1;
            frame_done_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            disp_q       <= disp_d;
            shadow_q     <= shadow_d;
            disp_valid_q <= disp_valid_d;
            pending_q    <= pending_d;
            hex_num_q    <= hex_num_d;
            digit_en_n_q <= digit_en_n_d;
            frame_done_q <= frame_done_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Next state, value routing and next outputs
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        disp_d       = disp_q;
        shadow_d     = shadow_q;
        disp_valid_d = disp_valid_q;
        pending_d    = pending_q;
        lit_c        = 1'b1;

        xfer_c     = in_if.in_valid && in_ready_q;
        boundary_c = enable && (state_q == ST_SCAN) &&
                     (idx_q == IW'(NUM_DIGITS - 1)) && (cnt_q == CW'(DWELL - 1));

        // Pending and new values land in the display register only when
        // idle or on a frame boundary, so a frame never shows mixed values.
        if (boundary_c && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end else if (xfer_c) begin
            if ((state_q == ST_IDLE) || boundary_c) begin
                disp_d       = in_if.in_value;
                disp_valid_d = 1'b1;
            end else begin
                shadow_d  = in_if.in_value;
                pending_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                cnt_d = '0;
                if (enable && disp_valid_d) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == CW'(GAP - 1)) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SCAN: begin
                if (cnt_q == CW'(DWELL - 1)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end

`ifdef SEG_SCAN_LZB_EN
        // nz_c[i]: some nibble at or above digit i is non-zero
        run_c = 1'b0;
        nz_c  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_c   = run_c | (disp_d[4*i +: 4] != 4'd0);
            nz_c[i] = run_c;
        end
        nz_c[0] = 1'b1;
        lit_c   = nz_c[idx_d];
`endif

        // Outputs are decoded from the next state so they align with it
        in_ready_d   = ~pending_d;
        hex_num_d    = (state_d == ST_IDLE) ? 4'd0 : disp_d[{idx_d, 2'b00} +: 4];
        digit_en_n_d = '1;
        if ((state_d == ST_SCAN) && lit_c) begin
            digit_en_n_d[idx_d] = 1'b0;
        end
        frame_done_d = (state_d == ST_SCAN) && (idx_d == IW'(NUM_DIGITS - 1)) &&
                       (cnt_d == CW'(DWELL - 1));
    end

    assign in_if.in_ready = in_ready_q;
    assign hex_num        = hex_num_q;
    assign digit_en_n     = digit_en_n_q;
    assign frame_done     = frame_done_q;
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares one hex-to-7-segment decoder across NUM_DIGITS common-anode digits.
- Accepts a packed hex value over a valid/ready handshake and drives the decoder's 4-bit nibble input plus active-low digit enables.
- Sequences digit dwell and inter-digit blanking periods.
- Sits between the board-level display register path and the shared decoder; the segment outputs go straight to the pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; legal range 2..8.
- DWELL, 50000: clock cycles each digit is lit per frame; must be >= 1.
- GAP, 16: blank cycles before each digit (anti-ghosting); must be >= 1.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable; 0 forces all digits dark.
- in_valid  in  1  source has a new value.
- in_ready  out  1  controller can accept a value.
- in_value  in  4*NUM_DIGITS  packed nibbles; digit 0 = in_value[3:0] (rightmost digit).
- hex_num  out  4  nibble to the shared decoder.
- digit_en_n  out  NUM_DIGITS  active-low digit enables; at most one bit is 0 at any time.
- frame_done  out  1  one-cycle pulse at the end of the last digit's dwell.

Behaviour:
- Reset is asynchronous and active-low. While reset_n=0:
  - hex_num=0, digit_en_n=all 1, in_ready=1, frame_done=0.
  - State=IDLE; internal digit index, counter, display register, shadow register, disp_valid and pending are all cleared.
  - Reset asserted mid-operation takes effect immediately, with no frame completion.
- All outputs are registered. in_ready = ~pending, registered.
- Handshake: a transfer occurs on a rising edge with in_valid=1 and in_ready=1. The value is routed as follows:
  - State IDLE: written directly to the display register; disp_valid<=1.
  - Cycle that is also a frame boundary: written directly to the display register and used from digit 0 of the next frame.
  - Otherwise: written to the shadow register; pending<=1.
- Pending value: moves shadow to display at the next frame boundary, then pending<=0. While pending=1, in_ready=0 and in_valid is ignored. Values are never dropped or overwritten.
- State machine:
  - IDLE: digit_en_n all 1, index=0, counter=0. Go to GAP when enable=1 and disp_valid=1 (including a value accepted in this same cycle).
  - GAP: digit_en_n all 1; hex_num=nibble[index]. After GAP cycles, go to SCAN with counter=0.
  - SCAN: digit_en_n[index]=0, all others 1; hex_num=nibble[index]. After DWELL cycles:
    - If index=NUM_DIGITS-1: frame boundary. frame_done=1 for one cycle, index<=0, shadow transfer if pending, go to GAP.
    - Else: index<=index+1, go to GAP.
- Frame length: NUM_DIGITS*(GAP+DWELL) cycles.
- enable falling in any state: on the next edge go to IDLE; all digits dark; index and counter cleared. The display register, shadow register and pending are retained. Re-enabling restarts at GAP, digit 0.
- Counter width: clog2 of max(DWELL,GAP)+1; it wraps only through explicit clears.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined: during SCAN, digit i stays dark (digit_en_n[i]=1) if nibbles i..NUM_DIGITS-1 of the display register are all zero. Digit 0 is never blanked. Slot timing is unchanged (the blank digit still consumes its DWELL).
- Undefined: every digit is lit in its slot.

Test Plan (bench uses NUM_DIGITS=4, DWELL=4, GAP=2):
- Reset, enable=1, load 0x1234 → 2 cycles of digit_en_n=1111, then 4 cycles of 1110 with hex_num=4; then digits 1/2/3 show 3/2/1 (enables 1101/1011/0111). frame_done pulses once, 24 cycles after GAP entry, then the frame repeats.
- Mid-frame, load 0xABCD, then present 0x5678 → in_ready falls after 0xABCD; 0x5678 is held off. At the boundary digit 0 shows D and in_ready rises. 0x5678 is accepted and shown from the following frame.
- Drop enable during digit 2 SCAN → next cycle digit_en_n=1111, state IDLE. Re-assert → 2 GAP cycles, then digit 0 lit.
- Pulse reset_n low mid-SCAN of digit 1 → outputs reach reset values without a clock edge. Controller stays dark until a new value is loaded.
- With SEG_SCAN_LZB_EN, load 0x0050 → digits 3 and 2 dark in their slots, digit 1 shows 5, digit 0 shows 0. Load 0x0000 → only digit 0 lit, showing 0. Without the macro, all four digits are lit.
- Load exactly on the frame_done cycle → value appears on digit 0 of the very next frame; pending stays 0.
